// File: rtl/ctrl_muestreo_if.sv
// Converter handshake bundle: level request from the sequencer, done strobe and raw
// comparator flags back from the converter.
interface ctrl_muestreo_if;
    logic conv_req;
    logic conv_ack;
    logic temp_raw;
    logic hum_raw;

    modport master (
        output conv_req,
        input  conv_ack,
        input  temp_raw,
        input  hum_raw
    );

    modport slave (
        input  conv_req,
        output conv_ack,
        output temp_raw,
        output hum_raw
    );
endinterface

// File: rtl/ctrl_muestreo.sv
// Danger-alarm sampling sequencer: periodic conversions, persistence filtering of the raw
// flags, arming delay for the alarm FSM and converter stall detection.
module ctrl_muestreo #(
    parameter int DIV_W       = 16,
    parameter int DIV         = 50000,
    parameter int PERSIST     = 3,
    parameter int ARM_SAMPLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    on,
    ctrl_muestreo_if.master         conv,
    output logic                    temp_alta,
    output logic                    hn,
    output logic                    en_alarma,
    output logic                    muestra_ok,
    output logic                    fallo
);

    typedef enum logic [2:0] {
        APAGADO,
        ESPERA,
        CONVIERTE,
        CAPTURA,
        FALLO
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);
    localparam logic [7:0]       TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [3:0]       PERS_MAX   = 4'(PERSIST);
    localparam logic [3:0]       ARM_MAX    = 4'(ARM_SAMPLES);

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] presc_reg, presc_next;
    logic [7:0]       tmo_reg, tmo_next;
    logic [3:0]       arm_reg, arm_next;
    logic             conv_req_reg;
    logic             en_alarma_reg;
    logic             muestra_ok_reg;
    logic             fallo_reg;
    logic             capture_go;
    logic [1:0]       raw_vec;
    logic [1:0]       flag_vec;

    // The raw flags are taken on the same edge that enters CAPTURA, so the filtered
    // outputs already show the new sample during the CAPTURA cycle.
    assign capture_go = on && (state_reg == CONVIERTE) && conv.conv_ack;
    assign raw_vec    = {conv.hum_raw, conv.temp_raw};

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        tmo_next   = tmo_reg;
        arm_next   = arm_reg;
        if (!on) begin
            state_next = APAGADO;
            presc_next = '0;
            tmo_next   = '0;
            arm_next   = '0;
        end else begin
            case (state_reg)
                APAGADO: begin
                    state_next = ESPERA;
                    presc_next = '0;
                end
                ESPERA: begin
                    if (presc_reg == PRESC_LAST) begin
                        state_next = CONVIERTE;
                        presc_next = '0;
                        tmo_next   = '0;
                    end else begin
                        presc_next = presc_reg + DIV_W'(1);
                    end
                end
                CONVIERTE: begin
                    // An ack on the last allowed cycle still counts as a capture.
                    if (conv.conv_ack) begin
                        state_next = CAPTURA;
                        if (arm_reg != ARM_MAX) begin
                            arm_next = arm_reg + 4'd1;
                        end
                    end else if (tmo_reg == TMO_LAST) begin
                        state_next = FALLO;
                    end else begin
                        tmo_next = tmo_reg + 8'd1;
                    end
                end
                CAPTURA: begin
                    state_next = ESPERA;
                    presc_next = '0;
                end
                FALLO: begin
                    state_next = FALLO;
                end
                default: begin
                    state_next = APAGADO;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            logic [3:0] cnt_reg, cnt_next;
            logic       flag_reg;

            always_comb begin
                cnt_next = cnt_reg;
                if (!on) begin
                    cnt_next = '0;
                end else if (capture_go) begin
                    if (!raw_vec[gi]) begin
                        cnt_next = '0;
                    end else if (cnt_reg != PERS_MAX) begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg  <= '0;
                    flag_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    flag_reg <= (cnt_next == PERS_MAX);
                end
            end

            assign flag_vec[gi] = flag_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= APAGADO;
            presc_reg      <= '0;
            tmo_reg        <= '0;
            arm_reg        <= '0;
            conv_req_reg   <= 1'b0;
            en_alarma_reg  <= 1'b0;
            muestra_ok_reg <= 1'b0;
            fallo_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            presc_reg      <= presc_next;
            tmo_reg        <= tmo_next;
            arm_reg        <= arm_next;
            conv_req_reg   <= (state_next == CONVIERTE);
            muestra_ok_reg <= (state_next == CAPTURA);
            fallo_reg      <= (state_next == FALLO);
            en_alarma_reg  <= (arm_next == ARM_MAX) &&
                              (state_next inside {ESPERA, CONVIERTE, CAPTURA});
        end
    end

    assign conv.conv_req = conv_req_reg;
    assign temp_alta     = flag_vec[0];
    assign hn            = flag_vec[1];
    assign en_alarma     = en_alarma_reg;
    assign muestra_ok    = muestra_ok_reg;
    assign fallo         = fallo_reg;

endmodule

// File: tb/tb_ctrl_muestreo.sv
// Bench for ctrl_muestreo: stimulus queues expected per-sample flags and snapshots,
// a negedge monitor pops and compares them.
module tb_ctrl_muestreo;

    logic clk = 1'b0;
    logic rst_n;
    logic on;
    logic temp_alta, hn, en_alarma, muestra_ok, fallo;

    ctrl_muestreo_if cif ();

    ctrl_muestreo #(
        .DIV_W      (16),
        .DIV        (4),
        .PERSIST    (3),
        .ARM_SAMPLES(2),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .on        (on),
        .conv      (cif.master),
        .temp_alta (temp_alta),
        .hn        (hn),
        .en_alarma (en_alarma),
        .muestra_ok(muestra_ok),
        .fallo     (fallo)
    );

    always #5 clk = ~clk;

    // Expected {temp_alta, hn, en_alarma} per capture, and queued one-off snapshots.
    logic [7:0] exp_q[$];
    string      obs_name[$];
    logic [7:0] obs_act[$];
    logic [7:0] obs_exp[$];

    int   err_cnt = 0;
    int   chk_cnt = 0;
    logic done    = 1'b0;
    logic prev_ok = 1'b0;

    // Bit map: 0 conv_req, 1 temp_alta, 2 hn, 3 en_alarma, 4 muestra_ok, 5 fallo
    function automatic logic [7:0] outs();
        return {2'b00, fallo, muestra_ok, en_alarma, hn, temp_alta, cif.conv_req};
    endfunction

    task automatic push(input string n, input logic [7:0] a, input logic [7:0] e);
        obs_name.push_back(n);
        obs_act.push_back(a);
        obs_exp.push_back(e);
    endtask

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        chk_cnt++;
        if (a !== e) begin
            err_cnt++;
            $display("FAIL %s: got %02h expected %02h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        while (obs_act.size() > 0) begin
            chk(obs_name.pop_front(), obs_act.pop_front(), obs_exp.pop_front());
        end
        if (muestra_ok) begin
            chk("sample_expected", 8'(exp_q.size() > 0), 8'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sample_flags", {5'b0, temp_alta, hn, en_alarma}, e);
                chk("capture_req_fallo_pulse", {5'b0, cif.conv_req, fallo, prev_ok}, 8'd0);
            end
        end
        prev_ok = muestra_ok;
        if (done) begin
            chk("pending_samples", 8'(exp_q.size()), 8'd0);
            $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_req(output int n);
        n = 0;
        while (!cif.conv_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!cif.conv_req) push("req_timeout", {7'b0, cif.conv_req}, 8'd1);
    endtask

    task automatic do_sample(input logic t, input logic h, input int lat, input logic [2:0] e);
        int n;
        wait_req(n);
        exp_q.push_back({5'b0, e});
        repeat (lat) @(negedge clk);
        cif.temp_raw = t;
        cif.hum_raw  = h;
        cif.conv_ack = 1'b1;
        @(negedge clk);
        cif.conv_ack = 1'b0;
        cif.temp_raw = 1'b0;
        cif.hum_raw  = 1'b0;
    endtask

    task automatic power_cycle();
        on = 1'b0;
        repeat (2) @(negedge clk);
        on = 1'b1;
    endtask

    // Test 3 table: raw temp sequence, ack latency, expected {t,h,en}
    logic [6:0] t3_raw = 7'b0111011;
    logic [2:0] t3_exp[7] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b101, 3'b001};

    initial begin
        int n;
        int cycles;
        rst_n        = 1'b0;
        on           = 1'b0;
        cif.conv_ack = 1'b0;
        cif.temp_raw = 1'b0;
        cif.hum_raw  = 1'b0;

        // 1: reset state, ESPERA length, async reset in CONVIERTE
        repeat (3) @(negedge clk);
        push("reset_outs", outs(), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        on = 1'b1;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cif.conv_req && n < 30);
        push("req_latency", 8'(n), 8'd5);
        #2 rst_n = 1'b0;
        #1 push("async_reset", outs(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cif.conv_req && n < 30);
        push("req_latency_after_reset", 8'(n), 8'd5);

        // 2: persistent ones on both flags, arming after two captures
        power_cycle();
        do_sample(1'b1, 1'b1, 2, 3'b000);
        do_sample(1'b1, 1'b1, 2, 3'b001);
        @(negedge clk);
        push("en_hold_espera", {7'b0, en_alarma}, 8'd1);
        do_sample(1'b1, 1'b1, 2, 3'b111);
        do_sample(1'b1, 1'b0, 2, 3'b101);

        // 3: broken run of ones restarts the persistence count
        power_cycle();
        for (int i = 0; i < 7; i++) begin
            do_sample(t3_raw[i], 1'b0, i % 4, t3_exp[i]);
        end

        // 4: stalled converter, ack ignored in FALLO, recovery through on=0
        power_cycle();
        do_sample(1'b1, 1'b0, 1, 3'b000);
        do_sample(1'b1, 1'b0, 1, 3'b001);
        do_sample(1'b1, 1'b0, 1, 3'b101);
        wait_req(n);
        cycles = 1;
        n      = 0;
        while (!fallo && n < 30) begin
            @(negedge clk);
            n++;
            if (cif.conv_req) cycles++;
        end
        push("timeout_cycles", 8'(cycles), 8'd8);
        push("fallo_outs", outs(), 8'h22);
        cif.conv_ack = 1'b1;
        @(negedge clk);
        cif.conv_ack = 1'b0;
        repeat (2) @(negedge clk);
        push("fallo_after_ack", outs(), 8'h22);
        on = 1'b0;
        @(negedge clk);
        push("off_clears", outs(), 8'h00);
        on = 1'b1;
        do_sample(1'b1, 1'b1, 1, 3'b000);

        // 5: ack on the timeout cycle wins, then on=0 mid-conversion
        do_sample(1'b1, 1'b1, 1, 3'b001);
        do_sample(1'b1, 1'b1, 7, 3'b111);
        @(negedge clk);
        push("no_fault_on_late_ack", {7'b0, fallo}, 8'd0);
        wait_req(n);
        push("pre_off", outs(), 8'h0F);
        on = 1'b0;
        @(negedge clk);
        push("off_mid_conv", outs(), 8'h00);
        on = 1'b1;
        do_sample(1'b1, 1'b0, 0, 3'b000);

        repeat (3) @(negedge clk);
        done = 1'b1;
    end

endmodule
